// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   common : iteration counts for full-width and word (W) operations.
//   pipes  : operation encoding (mdfunc_t), FSM state enum and small
//            decode helpers used by muldiv_seq.
// No ports; imported by rtl/muldiv_seq.sv and tb/tb_muldiv_seq.sv.

package common;

   localparam int MD_ITER64 = 64;
   localparam int MD_ITER32 = 32;

endpackage : common

package pipes;

   typedef enum logic [3:0] {
      MD_MUL,
      MD_MULW,
      MD_DIV,
      MD_DIVU,
      MD_REM,
      MD_REMU,
      MD_DIVW,
      MD_DIVUW,
      MD_REMW,
      MD_REMUW
   } mdfunc_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_t;

   // Word ops work on the low 32 bits and sign-extend the result from bit 31.
   function automatic logic op_is_w(input mdfunc_t f);
      case (f)
         MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   // Signed ops sign-extend word operands; for divides they also get the
   // magnitude/negation treatment.
   function automatic logic op_is_signed(input mdfunc_t f);
      case (f)
         MD_MUL, MD_MULW, MD_DIV, MD_REM, MD_DIVW, MD_REMW: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_div(input mdfunc_t f);
      return !(f == MD_MUL || f == MD_MULW);
   endfunction

   function automatic logic op_is_rem(input mdfunc_t f);
      case (f)
         MD_REM, MD_REMU, MD_REMW, MD_REMUW: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage : pipes

// File: rtl/muldiv_seq_step.sv
// One iteration of the sequential multiply/divide datapath (combinational).
// Ports:
//   is_div     : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc        : multiply partial product / divide partial remainder
//   mq         : multiplier (shifts right) / dividend-quotient (shifts left)
//   mcand      : multiplicand (shifts left) / divisor (constant)
//   *_nxt      : register values after this iteration

module muldiv_step (
   input  logic        is_div,
   input  logic [63:0] acc,
   input  logic [63:0] mq,
   input  logic [63:0] mcand,
   output logic [63:0] acc_nxt,
   output logic [63:0] mq_nxt,
   output logic [63:0] mcand_nxt
);

   // The shifted remainder can reach 2*divisor-1, so it needs a 65th bit;
   // the 65-bit difference is negative exactly when no subtraction fits.
   logic [64:0] rem_sh;
   logic [64:0] diff;

   always_comb begin
      // NOTE: every output gets a default first so no path can leave it
      // unassigned, which would otherwise infer a latch.
      rem_sh    = {acc, mq[63]};
      diff      = rem_sh - {1'b0, mcand};
      acc_nxt   = acc;
      mq_nxt    = mq;
      mcand_nxt = mcand;

      if (is_div) begin
         if (!diff[64]) begin
            acc_nxt = diff[63:0];
            mq_nxt  = {mq[62:0], 1'b1};
         end else begin
            acc_nxt = rem_sh[63:0];
            mq_nxt  = {mq[62:0], 1'b0};
         end
      end else begin
         acc_nxt   = acc + (mq[0] ? mcand : 64'd0);
         mq_nxt    = {1'b0, mq[63:1]};
         mcand_nxt = {mcand[62:0], 1'b0};
      end
   end

endmodule : muldiv_step

// File: rtl/muldiv_seq.sv
// Sequential integer multiply/divide unit (RV64M-style semantics).
// One shift-add or restoring shift-subtract iteration per BUSY cycle:
// 64 iterations for full-width ops, 32 for word ops. Divide-by-zero and
// signed overflow are resolved at acceptance and complete in one cycle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready high only in IDLE)
//   op, a, b            : operation and operands, captured on acceptance
//   flush               : abort any in-flight operation, return to IDLE
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   c                   : result, held stable while in DONE
//   busy                : high in BUSY or DONE

module muldiv_seq
   import common::*;
   import pipes::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  mdfunc_t       op,
   input  logic [63:0]   a,
   input  logic [63:0]   b,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   c,
   output logic          busy
);

   localparam logic [6:0] LAST64 = 7'(MD_ITER64 - 1);
   localparam logic [6:0] LAST32 = 7'(MD_ITER32 - 1);

   md_state_t   state_q, state_d;
   mdfunc_t     op_q;
   logic [6:0]  cnt_q;
   logic [63:0] acc_q, mq_q, mcand_q;
   logic        neg_q_q, neg_r_q;
   logic [63:0] c_q;

   // ---------------------------------------------------------------
   // Request decode (operates on the live inputs, used on acceptance)
   // ---------------------------------------------------------------
   logic        accept;
   logic        in_w, in_signed, in_div, in_rem;
   logic [63:0] a_ext, b_ext;
   logic        sign_a, sign_b;
   logic [63:0] mag_a, mag_b;
   logic        div_zero, div_ovf, special;
   logic [63:0] spec_raw, spec_res;

   assign accept    = in_valid && (state_q == MD_IDLE) && !flush;
   assign in_w      = op_is_w(op);
   assign in_signed = op_is_signed(op);
   assign in_div    = op_is_div(op);
   assign in_rem    = op_is_rem(op);

   assign a_ext = in_w ? (in_signed ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
   assign b_ext = in_w ? (in_signed ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;

   assign sign_a = in_signed && a_ext[63];
   assign sign_b = in_signed && b_ext[63];
   assign mag_a  = sign_a ? (64'd0 - a_ext) : a_ext;
   assign mag_b  = sign_b ? (64'd0 - b_ext) : b_ext;

   // Most-negative / -1 compares against the sign-extended form, so one
   // comparison covers both the 64-bit and the word case.
   assign div_zero = in_div && (b_ext == 64'd0);
   assign div_ovf  = in_div && in_signed && (b_ext == '1) &&
                     (a_ext == (in_w ? 64'hFFFF_FFFF_8000_0000
                                     : 64'h8000_0000_0000_0000));
   assign special  = div_zero || div_ovf;

   always_comb begin
      spec_raw = '1;
      if (div_zero) spec_raw = in_rem ? a_ext : '1;
      else          spec_raw = in_rem ? 64'd0 : a_ext;
      spec_res = in_w ? sext32(spec_raw[31:0]) : spec_raw;
   end

   // ---------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------
   logic [63:0] step_acc, step_mq, step_mcand;
   logic        last_iter;
   logic [63:0] res_raw, fin_res;

   muldiv_step u_step (
      .is_div    (op_is_div(op_q)),
      .acc       (acc_q),
      .mq        (mq_q),
      .mcand     (mcand_q),
      .acc_nxt   (step_acc),
      .mq_nxt    (step_mq),
      .mcand_nxt (step_mcand)
   );

   assign last_iter = (state_q == MD_BUSY) &&
                      (cnt_q == (op_is_w(op_q) ? LAST32 : LAST64));

   // Sign fix-up and word sign-extension, applied to the values the final
   // iteration produces so the result is registered on entry to DONE.
   always_comb begin
      res_raw = step_acc;
      if (op_is_div(op_q)) begin
         if (op_is_rem(op_q)) res_raw = neg_r_q ? (64'd0 - step_acc) : step_acc;
         else                 res_raw = neg_q_q ? (64'd0 - step_mq)  : step_mq;
      end
      fin_res = op_is_w(op_q) ? sext32(res_raw[31:0]) : res_raw;
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= MD_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (accept)    state_d = special ? MD_DONE : MD_BUSY;
         MD_BUSY: if (last_iter) state_d = MD_DONE;
         MD_DONE: if (out_ready) state_d = MD_IDLE;
         default:                state_d = MD_IDLE;
      endcase
      if (flush) state_d = MD_IDLE;
   end

   // ---------------------------------------------------------------
   // Operand / accumulator registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset along with the FSM so c is
      // never X, even before the first result; they are flops, not a RAM.
      if (reset) begin
         op_q    <= MD_MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         mcand_q <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         c_q     <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         if (accept) begin
            op_q    <= op;
            cnt_q   <= '0;
            acc_q   <= '0;
            neg_q_q <= in_div && (sign_a ^ sign_b);
            neg_r_q <= in_div && sign_a;
            if (in_div) begin
               // Word dividends start at bit 63 so the MSB-first shift works
               // unchanged; after 32 steps the quotient sits in mq[31:0].
               mq_q    <= in_w ? {mag_a[31:0], 32'd0} : mag_a;
               mcand_q <= mag_b;
            end else begin
               mq_q    <= b_ext;
               mcand_q <= a_ext;
            end
            if (special) c_q <= spec_res;
         end else if (state_q == MD_BUSY && !flush) begin
            acc_q   <= step_acc;
            mq_q    <= step_mq;
            mcand_q <= step_mcand;
            if (last_iter) begin
               cnt_q <= '0;
               c_q   <= fin_res;
            end else begin
               cnt_q <= cnt_q + 7'd1;
            end
         end else if (flush) begin
            cnt_q <= '0;
         end
      end
   end

   assign in_ready  = (state_q == MD_IDLE);
   assign out_valid = (state_q == MD_DONE);
   assign busy      = (state_q != MD_IDLE);
   assign c         = c_q;

endmodule : muldiv_seq

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.

module tb_muldiv_seq;
   import pipes::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   mdfunc_t     op;
   logic [63:0] a, b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] c;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic is_w_op(input mdfunc_t f);
      return f inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
   endfunction

   function automatic logic ref_special(input mdfunc_t f, input logic [63:0] x, input logic [63:0] y);
      case (f)
         MD_DIVU, MD_REMU:   return y == 64'd0;
         MD_DIVUW, MD_REMUW: return y[31:0] == 32'd0;
         MD_DIV, MD_REM:     return y == 64'd0 || (x == 64'h8000_0000_0000_0000 && y == '1);
         MD_DIVW, MD_REMW:   return y[31:0] == 32'd0 ||
                                    (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
         default:            return 1'b0;
      endcase
   endfunction

   function automatic int ref_lat(input mdfunc_t f, input logic [63:0] x, input logic [63:0] y);
      if (ref_special(f, x, y)) return 1;
      return is_w_op(f) ? 33 : 65;
   endfunction

   function automatic logic [63:0] ref_c(input mdfunc_t f, input logic [63:0] x, input logic [63:0] y);
      logic signed [63:0] sx, sy;
      logic signed [31:0] sx32, sy32;
      logic [31:0]        ux32, uy32, r32;
      sx = x; sy = y; sx32 = x[31:0]; sy32 = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
      case (f)
         MD_MUL:  return x * y;
         MD_MULW: begin r32 = ux32 * uy32; return {{32{r32[31]}}, r32}; end
         MD_DIV: begin
            if (y == 0) return '1;
            if (x == 64'h8000_0000_0000_0000 && y == '1) return x;
            return sx / sy;
         end
         MD_REM: begin
            if (y == 0) return x;
            if (x == 64'h8000_0000_0000_0000 && y == '1) return 64'd0;
            return sx % sy;
         end
         MD_DIVU: return (y == 0) ? '1 : x / y;
         MD_REMU: return (y == 0) ? x : x % y;
         MD_DIVW: begin
            if (uy32 == 0) r32 = '1;
            else if (sx32 == -32'sd2147483648 && sy32 == -32'sd1) r32 = ux32;
            else r32 = sx32 / sy32;
            return {{32{r32[31]}}, r32};
         end
         MD_DIVUW: begin
            r32 = (uy32 == 0) ? '1 : ux32 / uy32;
            return {{32{r32[31]}}, r32};
         end
         MD_REMW: begin
            if (uy32 == 0) r32 = ux32;
            else if (sx32 == -32'sd2147483648 && sy32 == -32'sd1) r32 = 32'd0;
            else r32 = sx32 % sy32;
            return {{32{r32[31]}}, r32};
         end
         default: begin // MD_REMUW
            r32 = (uy32 == 0) ? ux32 : ux32 % uy32;
            return {{32{r32[31]}}, r32};
         end
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Presents one request at a negedge (cycle 0), scrambles the inputs once
   // accepted, measures latency to out_valid, optionally stalls the result.
   task automatic do_op(input mdfunc_t f, input logic [63:0] x, input logic [63:0] y,
                        input int stall);
      logic [63:0] exp_c;
      int          exp_lat;
      int          lat;
      exp_c   = ref_c(f, x, y);
      exp_lat = ref_lat(f, x, y);
      check("in_ready_idle", in_ready, 1);
      op = f; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op = mdfunc_t'(4'($urandom_range(0, 9)));
      a  = rand64();
      b  = rand64();
      check("busy_cycle1", busy, 1);
      check("in_ready_cycle1", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency_%s", f.name()), lat, exp_lat);
      check($sformatf("c_%s", f.name()), c, exp_c);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_c", c, exp_c);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("in_ready_after", in_ready, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int seen;
      reset = 1'b1; in_valid = 1'b0; op = MD_MUL; a = '0; b = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_c", c, 64'd0);

      // Directed cases
      do_op(MD_MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      do_op(MD_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
      do_op(MD_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
      do_op(MD_DIVU, 64'd5, 64'd0, 0);
      do_op(MD_REMU, 64'd5, 64'd0, 0);
      do_op(MD_DIV,  64'h8000_0000_0000_0000, '1, 0);
      do_op(MD_REM,  64'h8000_0000_0000_0000, '1, 0);
      do_op(MD_DIVUW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5);
      do_op(MD_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
      do_op(MD_REMUW, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 2);
      do_op(MD_MULW, 64'h0000_0000_7FFF_FFFF, 64'd3, 0);

      // Flush in cycle 10 of a multiply, then a divide accepted in cycle 11
      check("pre_flush_ready", in_ready, 1);
      op = MD_MUL; a = 64'd3; b = 64'd9; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      seen = 0;
      for (int i = 1; i < 10; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_no_valid", seen + int'(out_valid), 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_busy", busy, 0);
      do_op(MD_DIVU, 64'd100, 64'd7, 0);

      // Flush overrides in_valid in IDLE
      op = MD_DIV; a = 64'd10; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_blocks_accept", busy, 0);

      // Reset mid-operation discards the op
      op = MD_DIVU; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1; flush = 1'b1;
      @(negedge clk);
      reset = 1'b0; flush = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_c", c, 64'd0);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("midrst_no_valid", seen, 0);

      // Random operations with a bias towards the corner cases
      for (int n = 0; n < 40; n++) begin
         mdfunc_t     f;
         logic [63:0] x, y;
         f = mdfunc_t'(4'($urandom_range(0, 9)));
         x = rand64();
         y = rand64();
         case ($urandom_range(0, 5))
            0: y = (is_w_op(f) && $urandom_range(0, 1) == 1) ? {y[63:32], 32'd0} : 64'd0;
            1: begin
               x = is_w_op(f) ? {x[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
               y = is_w_op(f) ? {y[63:32], 32'hFFFF_FFFF} : '1;
            end
            2: begin
               x = 64'($urandom_range(0, 1000));
               y = 64'($urandom_range(1, 20));
            end
            default: ;
         endcase
         do_op(f, x, y, int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_muldiv_seq
